// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers for the pipelined MIPS core.
// Results are computed when the op is accepted and committed to HI/LO after a fixed latency.
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     phi_q, phi_d;
    logic [31:0]     plo_q, plo_d;

    logic        is_mul, is_div, commit, launch;
    logic        a_neg, b_neg;
    logic [63:0] prod;
    logic [31:0] abs_a, abs_b, uq, ur, quot, rem;

    // Signed divide is done on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        is_mul = (op == OpMult) || (op == OpMultu);
        is_div = (op == OpDiv) || (op == OpDivu);
        prod   = {{32{(op == OpMult) & a[31]}}, a} * {{32{(op == OpMult) & b[31]}}, b};
        a_neg  = (op == OpDiv) & a[31];
        b_neg  = (op == OpDiv) & b[31];
        abs_a  = a_neg ? (~a + 32'd1) : a;
        abs_b  = b_neg ? (~b + 32'd1) : b;
        if (b == 32'd0) begin
            uq = '0;
            ur = '0;
        end else begin
            uq = abs_a / abs_b;
            ur = abs_a % abs_b;
        end
        quot = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem  = a_neg ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        commit  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && op == OpMthi) begin
                    hi_d = a;
                end else if (start && op == OpMtlo) begin
                    lo_d = a;
                end
            end
            StMul, StDiv: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    commit  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (!dz_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A mul/div may also launch on the commit edge so back-to-back ops leave no bubble.
        launch = start && (is_mul || is_div) && ((state_q == StIdle) || commit);
        if (launch) begin
            busy_d = 1'b1;
            if (is_mul) begin
                {phi_d, plo_d} = prod;
                dz_d           = 1'b0;
                cnt_d          = CntW'(MULT_CYCLES);
                state_d        = StMul;
            end else begin
                phi_d   = rem;
                plo_d   = quot;
                dz_d    = (b == 32'd0);
                cnt_d   = CntW'(DIV_CYCLES);
                state_d = StDiv;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = busy_q | (start & (is_mul | is_div));

endmodule
